// File: rtl/seq_mag_comparator_if.sv
// Request/response bundle for the slice-serial magnitude comparator.
// The master drives the operands and control; the slave returns status and flags.
interface seq_mag_comparator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             clear;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    modport master (
        output start, clear, signed_mode, a, b,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  start, clear, signed_mode, a, b,
        output busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks SLICE-bit slices from the MSB end,
// stopping at the first differing slice. Signed compares use offset-binary
// (MSB inverted on the top slice only).
module seq_mag_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_mag_comparator_if.slave  bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || SLICE == 0) begin : g_bad_params
        $error("WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_a, w_a_d;
    logic [WIDTH-1:0] r_b, w_b_d;
    logic             r_signed, w_signed_d;
    logic [IDXW-1:0]  r_idx, w_idx_d;
    logic             r_done, w_done_d;
    logic             r_gt, w_gt_d;
    logic             r_eq, w_eq_d;
    logic             r_lt, w_lt_d;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;

    // Select the current slice of each captured operand; offset-binary fix on the top slice.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int unsigned s = 0; s < NSLICE; s++) begin
            if (r_idx == IDXW'(s)) begin
                w_a_slice = r_a[s*SLICE +: SLICE];
                w_b_slice = r_b[s*SLICE +: SLICE];
            end
        end
        if (r_signed && (r_idx == TOP_IDX)) begin
            w_a_slice[SLICE-1] = ~w_a_slice[SLICE-1];
            w_b_slice[SLICE-1] = ~w_b_slice[SLICE-1];
        end
    end

    // Next-state: accept in idle, compare one slice per cycle in run; clear overrides all.
    always_comb begin
        w_state_d  = r_state;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_signed_d = r_signed;
        w_idx_d    = r_idx;
        w_done_d   = 1'b0;
        w_gt_d     = r_gt;
        w_eq_d     = r_eq;
        w_lt_d     = r_lt;

        if (bus.clear) begin
            w_state_d = StIdle;
            w_gt_d    = 1'b0;
            w_eq_d    = 1'b0;
            w_lt_d    = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        w_a_d      = bus.a;
                        w_b_d      = bus.b;
                        w_signed_d = bus.signed_mode;
                        w_idx_d    = TOP_IDX;
                        w_gt_d     = 1'b0;
                        w_eq_d     = 1'b0;
                        w_lt_d     = 1'b0;
                        w_state_d  = StRun;
                    end
                end
                StRun: begin
                    if (w_a_slice > w_b_slice) begin
                        w_gt_d    = 1'b1;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else if (w_a_slice < w_b_slice) begin
                        w_lt_d    = 1'b1;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else if (r_idx == '0) begin
                        w_eq_d    = 1'b1;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_idx_d = r_idx - IDXW'(1);
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_signed <= w_signed_d;
            r_idx    <= w_idx_d;
            r_done   <= w_done_d;
            r_gt     <= w_gt_d;
            r_eq     <= w_eq_d;
            r_lt     <= w_lt_d;
        end
    end

    assign bus.busy   = (r_state == StRun);
    assign bus.done   = r_done;
    assign bus.a_gt_b = r_gt;
    assign bus.a_eq_b = r_eq;
    assign bus.a_lt_b = r_lt;
endmodule
